amb_surucu: RTL

//  Execute-stage issue block that drives the combinational ALU (amb) interface: accepts decoded ops by valid/ready,

---
 rtl/amb_surucu_pkg.sv | 32 +++
 rtl/amb_islenen_secici.sv | 54 +++++
 rtl/amb_surucu.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/amb_surucu_pkg.sv
// Shared ALU operation codes and default widths for the execute stage.
// Every block that talks to the ALU imports these instead of keeping its own copy.
package amb_surucu_pkg;

    localparam int VERI_BIT_VARSAYILAN  = 32;
    localparam int ADR_BIT_VARSAYILAN   = 5;
    localparam int SAYAC_BIT_VARSAYILAN = 32;

    typedef enum logic [3:0] {
        AMB_TOPLAMA = 4'd0,
        AMB_CIKARMA = 4'd1,
        AMB_XOR     = 4'd2,
        AMB_OR      = 4'd3,
        AMB_AND     = 4'd4,
        AMB_SLL     = 4'd5,
        AMB_SRL     = 4'd6,
        AMB_SRA     = 4'd7,
        AMB_SLT     = 4'd8,
        AMB_SLTU    = 4'd9,
        AMB_GECIR   = 4'd10
    } amb_kod_e;

    // Codes 11..15 are unassigned; an op carrying one is reported as an error.
    function automatic logic kontrol_tanimli(input logic [3:0] kontrol);
        case (kontrol)
            AMB_TOPLAMA, AMB_CIKARMA, AMB_XOR, AMB_OR, AMB_AND,
            AMB_SLL, AMB_SRL, AMB_SRA, AMB_SLT, AMB_SLTU, AMB_GECIR: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/amb_islenen_secici.sv
// Combinational operand selection for the ALU: register/PC for deger1, register/immediate for deger2.
// With AMB_GERI_BESLEME_EN defined, a register operand matching the pending result's destination takes sonuc instead.
module amb_islenen_secici
    import amb_surucu_pkg::*;
#(
    parameter int VERI_BIT = VERI_BIT_VARSAYILAN,
    parameter int ADR_BIT  = ADR_BIT_VARSAYILAN
) (
    input  logic                gecerli_i,
    input  logic                deger1_sec_i,
    input  logic                deger2_sec_i,
    input  logic [VERI_BIT-1:0] kaynak1_i,
    input  logic [VERI_BIT-1:0] kaynak2_i,
    input  logic [ADR_BIT-1:0]  kaynak1_adr_i,
    input  logic [ADR_BIT-1:0]  kaynak2_adr_i,
    input  logic [VERI_BIT-1:0] ps_i,
    input  logic [VERI_BIT-1:0] anlik_i,
    input  logic                sonuc_gecerli_i,
    input  logic [ADR_BIT-1:0]  sonuc_hedef_i,
    input  logic [VERI_BIT-1:0] sonuc_i,
    output logic [VERI_BIT-1:0] deger1_o,
    output logic [VERI_BIT-1:0] deger2_o
);

    logic [VERI_BIT-1:0] islenen1;
    logic [VERI_BIT-1:0] islenen2;

`ifdef AMB_GERI_BESLEME_EN
    logic atla1;
    logic atla2;

    // x0 is hard-wired zero, so a result aimed at it is never forwarded.
    assign atla1 = sonuc_gecerli_i && (sonuc_hedef_i != '0) && (kaynak1_adr_i == sonuc_hedef_i);
    assign atla2 = sonuc_gecerli_i && (sonuc_hedef_i != '0) && (kaynak2_adr_i == sonuc_hedef_i);
    assign islenen1 = atla1 ? sonuc_i : kaynak1_i;
    assign islenen2 = atla2 ? sonuc_i : kaynak2_i;
`else
    logic unused_geri_besleme;

    assign unused_geri_besleme = ^{sonuc_gecerli_i, sonuc_hedef_i, sonuc_i, kaynak1_adr_i, kaynak2_adr_i};
    assign islenen1 = kaynak1_i;
    assign islenen2 = kaynak2_i;
`endif

    always_comb begin
        deger1_o = '0;
        deger2_o = '0;
        if (gecerli_i) begin
            deger1_o = deger1_sec_i ? ps_i    : islenen1;
            deger2_o = deger2_sec_i ? anlik_i : islenen2;
        end
    end

endmodule

// File: rtl/amb_surucu.sv
// Execute-stage issue block: issue register -> external combinational ALU -> result register, valid/ready both sides.
// Optional result forwarding into the operand mux is enabled with AMB_GERI_BESLEME_EN.
module amb_surucu
    import amb_surucu_pkg::*;
#(
    parameter int VERI_BIT  = VERI_BIT_VARSAYILAN,
    parameter int ADR_BIT   = ADR_BIT_VARSAYILAN,
    parameter int SAYAC_BIT = SAYAC_BIT_VARSAYILAN
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 temizle_i,
    input  logic                 gecerli_i,
    output logic                 hazir_o,
    input  logic [3:0]           kontrol_i,
    input  logic [VERI_BIT-1:0]  kaynak1_i,
    input  logic [ADR_BIT-1:0]   kaynak1_adr_i,
    input  logic [VERI_BIT-1:0]  kaynak2_i,
    input  logic [ADR_BIT-1:0]   kaynak2_adr_i,
    input  logic [VERI_BIT-1:0]  anlik_i,
    input  logic [VERI_BIT-1:0]  ps_i,
    input  logic                 deger1_sec_i,
    input  logic                 deger2_sec_i,
    input  logic [ADR_BIT-1:0]   hedef_adr_i,
    output logic [3:0]           amb_kontrol_o,
    output logic [VERI_BIT-1:0]  amb_deger1_o,
    output logic [VERI_BIT-1:0]  amb_deger2_o,
    input  logic [VERI_BIT-1:0]  amb_sonuc_i,
    output logic                 sonuc_gecerli_o,
    input  logic                 sonuc_hazir_i,
    output logic [VERI_BIT-1:0]  sonuc_o,
    output logic [ADR_BIT-1:0]   sonuc_hedef_o,
    output logic                 sonuc_hata_o,
    output logic [SAYAC_BIT-1:0] islem_sayisi_o
);

    logic                 s1_gecerli_d,  s1_gecerli_q;
    logic [3:0]           kontrol_d,     kontrol_q;
    logic [VERI_BIT-1:0]  kaynak1_d,     kaynak1_q;
    logic [VERI_BIT-1:0]  kaynak2_d,     kaynak2_q;
    logic [ADR_BIT-1:0]   kaynak1_adr_d, kaynak1_adr_q;
    logic [ADR_BIT-1:0]   kaynak2_adr_d, kaynak2_adr_q;
    logic [VERI_BIT-1:0]  anlik_d,       anlik_q;
    logic [VERI_BIT-1:0]  ps_d,          ps_q;
    logic                 deger1_sec_d,  deger1_sec_q;
    logic                 deger2_sec_d,  deger2_sec_q;
    logic [ADR_BIT-1:0]   hedef_d,       hedef_q;

    logic                 sonuc_gecerli_d, sonuc_gecerli_q;
    logic [VERI_BIT-1:0]  sonuc_d,         sonuc_q;
    logic [ADR_BIT-1:0]   sonuc_hedef_d,   sonuc_hedef_q;
    logic                 sonuc_hata_d,    sonuc_hata_q;
    logic [SAYAC_BIT-1:0] sayac_d,         sayac_q;

    logic ilerle;
    logic giris_al;
    logic cikis_al;
    logic hata;

    // Stage 1 may move forward whenever the result slot is empty or being drained this cycle.
    assign ilerle   = s1_gecerli_q & (~sonuc_gecerli_q | sonuc_hazir_i);
    assign hazir_o  = ~s1_gecerli_q | ilerle;
    assign giris_al = gecerli_i & hazir_o;
    assign cikis_al = sonuc_gecerli_q & sonuc_hazir_i;
    assign hata     = ~kontrol_tanimli(kontrol_q);

    assign amb_kontrol_o = s1_gecerli_q ? kontrol_q : AMB_GECIR;

    amb_islenen_secici #(
        .VERI_BIT (VERI_BIT),
        .ADR_BIT  (ADR_BIT)
    ) u_secici (
        .gecerli_i       (s1_gecerli_q),
        .deger1_sec_i    (deger1_sec_q),
        .deger2_sec_i    (deger2_sec_q),
        .kaynak1_i       (kaynak1_q),
        .kaynak2_i       (kaynak2_q),
        .kaynak1_adr_i   (kaynak1_adr_q),
        .kaynak2_adr_i   (kaynak2_adr_q),
        .ps_i            (ps_q),
        .anlik_i         (anlik_q),
        .sonuc_gecerli_i (sonuc_gecerli_q),
        .sonuc_hedef_i   (sonuc_hedef_q),
        .sonuc_i         (sonuc_q),
        .deger1_o        (amb_deger1_o),
        .deger2_o        (amb_deger2_o)
    );

    always_comb begin
        s1_gecerli_d    = s1_gecerli_q;
        kontrol_d       = kontrol_q;
        kaynak1_d       = kaynak1_q;
        kaynak2_d       = kaynak2_q;
        kaynak1_adr_d   = kaynak1_adr_q;
        kaynak2_adr_d   = kaynak2_adr_q;
        anlik_d         = anlik_q;
        ps_d            = ps_q;
        deger1_sec_d    = deger1_sec_q;
        deger2_sec_d    = deger2_sec_q;
        hedef_d         = hedef_q;
        sonuc_gecerli_d = sonuc_gecerli_q;
        sonuc_d         = sonuc_q;
        sonuc_hedef_d   = sonuc_hedef_q;
        sonuc_hata_d    = sonuc_hata_q;
        sayac_d         = sayac_q;

        if (giris_al) begin
            s1_gecerli_d  = 1'b1;
            kontrol_d     = kontrol_i;
            kaynak1_d     = kaynak1_i;
            kaynak2_d     = kaynak2_i;
            kaynak1_adr_d = kaynak1_adr_i;
            kaynak2_adr_d = kaynak2_adr_i;
            anlik_d       = anlik_i;
            ps_d          = ps_i;
            deger1_sec_d  = deger1_sec_i;
            deger2_sec_d  = deger2_sec_i;
            hedef_d       = hedef_adr_i;
        end else if (ilerle) begin
            s1_gecerli_d = 1'b0;
        end

        // A new result replaces a drained one in the same cycle, so valid stays high with no bubble.
        if (ilerle) begin
            sonuc_gecerli_d = 1'b1;
            sonuc_d         = hata ? '0 : amb_sonuc_i;
            sonuc_hedef_d   = hedef_q;
            sonuc_hata_d    = hata;
        end else if (cikis_al) begin
            sonuc_gecerli_d = 1'b0;
        end

        if (cikis_al) begin
            sayac_d = sayac_q + SAYAC_BIT'(1);
        end

        if (temizle_i) begin
            s1_gecerli_d    = 1'b0;
            sonuc_gecerli_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_gecerli_q    <= 1'b0;
            kontrol_q       <= '0;
            kaynak1_q       <= '0;
            kaynak2_q       <= '0;
            kaynak1_adr_q   <= '0;
            kaynak2_adr_q   <= '0;
            anlik_q         <= '0;
            ps_q            <= '0;
            deger1_sec_q    <= 1'b0;
            deger2_sec_q    <= 1'b0;
            hedef_q         <= '0;
            sonuc_gecerli_q <= 1'b0;
            sonuc_q         <= '0;
            sonuc_hedef_q   <= '0;
            sonuc_hata_q    <= 1'b0;
            sayac_q         <= '0;
        end else begin
            s1_gecerli_q    <= s1_gecerli_d;
            kontrol_q       <= kontrol_d;
            kaynak1_q       <= kaynak1_d;
            kaynak2_q       <= kaynak2_d;
            kaynak1_adr_q   <= kaynak1_adr_d;
            kaynak2_adr_q   <= kaynak2_adr_d;
            anlik_q         <= anlik_d;
            ps_q            <= ps_d;
            deger1_sec_q    <= deger1_sec_d;
            deger2_sec_q    <= deger2_sec_d;
            hedef_q         <= hedef_d;
            sonuc_gecerli_q <= sonuc_gecerli_d;
            sonuc_q         <= sonuc_d;
            sonuc_hedef_q   <= sonuc_hedef_d;
            sonuc_hata_q    <= sonuc_hata_d;
            sayac_q         <= sayac_d;
        end
    end

    assign sonuc_gecerli_o = sonuc_gecerli_q;
    assign sonuc_o         = sonuc_q;
    assign sonuc_hedef_o   = sonuc_hedef_q;
    assign sonuc_hata_o    = sonuc_hata_q;
    assign islem_sayisi_o  = sayac_q;

endmodule
